// File: rtl/elevator_pkg.sv
// Shared types and floor constants for the elevator car controller.
package elevator_pkg;

   typedef logic [1:0] floor_t;

   localparam floor_t ST_FLOOR  = 2'b00;
   localparam floor_t ND_FLOOR  = 2'b01;
   localparam floor_t RD_FLOOR  = 2'b10;
   localparam floor_t INV_FLOOR = 2'b11;

   typedef enum logic [1:0] {IDLE, MOVE, DOOR} fc_state_t;

   // Maps a floor onto its bit in the {rd,nd,st} call/clear vectors.
   function automatic logic [2:0] floor_onehot(input floor_t f);
      logic [2:0] oh;
      oh = 3'b000;
      case (f)
         ST_FLOOR: oh = 3'b001;
         ND_FLOOR: oh = 3'b010;
         RD_FLOOR: oh = 3'b100;
         default:  oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/elevator_floor_control_timer.sv
// Cycle counter shared by the travel and door-dwell phases of the car controller.
module elevator_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/elevator_floor_control.sv
// Car controller: moves one floor per travel period toward the queued stop and dwells with the door open.
// Optional door-hold button support is enabled by defining ELEV_DOOR_HOLD_EN.
module elevator_floor_control
   import elevator_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 16,
   parameter int DOOR_CYCLES   = 32,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] open_when,
   input  logic [2:0] call,
   input  logic       door_hold,
   output logic [1:0] floor,
   output logic       is_mooving,
   output logic       door_open,
   output logic [2:0] led_clr
);

   localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

   fc_state_t        state, state_n;
   floor_t           floor_n, dest, dest_n;
   logic             dir_up, dir_up_n;
   logic [2:0]       led_clr_n;
   logic             t_clr, t_en;
   logic [CNT_W-1:0] timer;
   logic             hold_active;

`ifdef ELEV_DOOR_HOLD_EN
   assign hold_active = door_hold;
`else
   logic unused_door_hold;
   assign unused_door_hold = door_hold;
   assign hold_active      = 1'b0;
`endif

   elevator_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (t_clr),
      .en    (t_en),
      .count (timer)
   );

   always_comb begin
      state_n   = state;
      floor_n   = floor;
      dest_n    = dest;
      dir_up_n  = dir_up;
      led_clr_n = 3'b000;
      t_clr     = 1'b0;
      t_en      = 1'b0;
      case (state)
         IDLE: begin
            if (call[floor]) begin
               state_n   = DOOR;
               t_clr     = 1'b1;
               led_clr_n = floor_onehot(floor);
            end else if (open_when != INV_FLOOR && open_when != floor) begin
               // The decision cycle already counts as the first travel cycle.
               state_n  = MOVE;
               dest_n   = open_when;
               dir_up_n = (open_when > floor);
               t_en     = 1'b1;
            end else begin
               t_clr = 1'b1;
            end
         end
         MOVE: begin
            if (timer == TRAVEL_LAST) begin
               t_clr   = 1'b1;
               floor_n = dir_up ? floor + 2'd1 : floor - 2'd1;
               if (floor_n == dest) begin
                  state_n   = DOOR;
                  led_clr_n = floor_onehot(floor_n);
               end
            end else begin
               t_en = 1'b1;
            end
         end
         DOOR: begin
            // Skip the cycle where our own clear pulse is still in flight upstream.
            if (call[floor] && !led_clr[floor]) begin
               led_clr_n = floor_onehot(floor);
            end
            if (hold_active) begin
               t_clr = 1'b1;
            end else if (timer == DOOR_LAST) begin
               t_clr   = 1'b1;
               state_n = IDLE;
            end else begin
               t_en = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            t_clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         floor      <= ST_FLOOR;
         dest       <= ST_FLOOR;
         dir_up     <= 1'b0;
         is_mooving <= 1'b0;
         door_open  <= 1'b0;
         led_clr    <= 3'b000;
      end else begin
         state      <= state_n;
         floor      <= floor_n;
         dest       <= dest_n;
         dir_up     <= dir_up_n;
         is_mooving <= (state_n == MOVE);
         door_open  <= (state_n == DOOR);
         led_clr    <= led_clr_n;
      end
   end

endmodule

// File: tb/tb_elevator_floor_control.sv
// Directed bench for elevator_floor_control with TRAVEL_CYCLES=4, DOOR_CYCLES=6.
module tb_elevator_floor_control;

   localparam int TRAVEL = 4;
   localparam int DWELL  = 6;
`ifdef ELEV_DOOR_HOLD_EN
   localparam int HOLD_CLOSE = 17;
`else
   localparam int HOLD_CLOSE = 7;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] open_when = 2'b00;
   logic [2:0] call = 3'b000;
   logic       door_hold = 1'b0;
   logic [1:0] floor;
   logic       is_mooving;
   logic       door_open;
   logic [2:0] led_clr;

   int checks = 0;
   int failures = 0;

   elevator_floor_control #(
      .TRAVEL_CYCLES (TRAVEL),
      .DOOR_CYCLES   (DWELL),
      .CNT_W         (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .open_when  (open_when),
      .call       (call),
      .door_hold  (door_hold),
      .floor      (floor),
      .is_mooving (is_mooving),
      .door_open  (door_open),
      .led_clr    (led_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      open_when = 2'b00;
      call      = 3'b000;
      door_hold = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({floor, is_mooving, door_open, led_clr} !== 7'b00_0_0_000) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=%b", {floor, is_mooving, door_open, led_clr}, 7'b00_0_0_000);
      end
   endtask

   task automatic test_trip_up();
      int pulses;
      pulses    = 0;
      do_reset();
      open_when = 2'b10;
      call      = 3'b100;
      rst_n     = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (led_clr != 3'b000) pulses++;
         if (c == 1) begin
            checks++;
            if ({floor, is_mooving} !== 3'b00_1) begin
               failures++;
               $display("FAIL trip_start got=%b exp=%b", {floor, is_mooving}, 3'b00_1);
            end
         end
         if (c == 4) begin
            checks++;
            if ({floor, is_mooving} !== 3'b01_1) begin
               failures++;
               $display("FAIL trip_pass_f2 got=%b exp=%b", {floor, is_mooving}, 3'b01_1);
            end
         end
         if (c == 8) begin
            checks++;
            if ({floor, is_mooving, door_open, led_clr} !== 7'b10_0_1_100) begin
               failures++;
               $display("FAIL trip_arrive got=%b exp=%b", {floor, is_mooving, door_open, led_clr}, 7'b10_0_1_100);
            end
            call = 3'b000;
         end
         if (c == 13) begin
            checks++;
            if (door_open !== 1'b1) begin
               failures++;
               $display("FAIL trip_door_last got=%b exp=1", door_open);
            end
         end
         if (c == 14) begin
            checks++;
            if ({is_mooving, door_open} !== 2'b00) begin
               failures++;
               $display("FAIL trip_door_close got=%b exp=00", {is_mooving, door_open});
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL trip_clr_pulses got=%0d exp=1", pulses);
      end
   endtask

   task automatic test_down_to_2();
      open_when = 2'b01;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) begin
            checks++;
            if ({floor, is_mooving} !== 3'b10_1) begin
               failures++;
               $display("FAIL down_start got=%b exp=%b", {floor, is_mooving}, 3'b10_1);
            end
         end
         if (c == 4) begin
            checks++;
            if ({floor, is_mooving, door_open, led_clr} !== 7'b01_0_1_010) begin
               failures++;
               $display("FAIL down_arrive got=%b exp=%b", {floor, is_mooving, door_open, led_clr}, 7'b01_0_1_010);
            end
         end
         if (c == 9) begin
            checks++;
            if (door_open !== 1'b1) begin
               failures++;
               $display("FAIL down_door_last got=%b exp=1", door_open);
            end
         end
         if (c == 10) begin
            checks++;
            if (door_open !== 1'b0) begin
               failures++;
               $display("FAIL down_door_close got=%b exp=0", door_open);
            end
         end
      end
   endtask

   task automatic test_call_at_floor();
      call = 3'b010;
      tick();
      checks++;
      if ({floor, is_mooving, door_open, led_clr} !== 7'b01_0_1_010) begin
         failures++;
         $display("FAIL call_here_open got=%b exp=%b", {floor, is_mooving, door_open, led_clr}, 7'b01_0_1_010);
      end
      call = 3'b000;
      for (int c = 2; c <= 7; c++) begin
         tick();
         if (c == 2) begin
            checks++;
            if (led_clr !== 3'b000) begin
               failures++;
               $display("FAIL call_here_pulse_end got=%b exp=000", led_clr);
            end
         end
         if (c == 6) begin
            checks++;
            if (door_open !== 1'b1) begin
               failures++;
               $display("FAIL call_here_door_last got=%b exp=1", door_open);
            end
         end
         if (c == 7) begin
            checks++;
            if ({is_mooving, door_open} !== 2'b00) begin
               failures++;
               $display("FAIL call_here_close got=%b exp=00", {is_mooving, door_open});
            end
         end
      end
   endtask

   task automatic test_invalid_idle();
      open_when = 2'b11;
      for (int c = 1; c <= 5; c++) begin
         tick();
         checks++;
         if ({floor, is_mooving, door_open, led_clr} !== 7'b01_0_0_000) begin
            failures++;
            $display("FAIL invalid_stay_c%0d got=%b exp=%b", c, {floor, is_mooving, door_open, led_clr}, 7'b01_0_0_000);
         end
      end
   endtask

   task automatic test_ignore_midtrip();
      do_reset();
      open_when = 2'b10;
      rst_n     = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 2) open_when = 2'b01;
         if (c == 4) begin
            checks++;
            if ({floor, is_mooving, door_open} !== 4'b01_1_0) begin
               failures++;
               $display("FAIL midtrip_no_stop got=%b exp=%b", {floor, is_mooving, door_open}, 4'b01_1_0);
            end
         end
         if (c == 8) begin
            checks++;
            if ({floor, is_mooving, door_open, led_clr} !== 7'b10_0_1_100) begin
               failures++;
               $display("FAIL midtrip_arrive got=%b exp=%b", {floor, is_mooving, door_open, led_clr}, 7'b10_0_1_100);
            end
         end
      end
   endtask

   task automatic test_reset_mid_move();
      do_reset();
      open_when = 2'b10;
      rst_n     = 1'b1;
      repeat (5) tick();
      checks++;
      if ({floor, is_mooving} !== 3'b01_1) begin
         failures++;
         $display("FAIL rstmid_pre got=%b exp=%b", {floor, is_mooving}, 3'b01_1);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({floor, is_mooving, door_open} !== 4'b00_0_0) begin
         failures++;
         $display("FAIL rstmid_async got=%b exp=%b", {floor, is_mooving, door_open}, 4'b00_0_0);
      end
      open_when = 2'b00;
      call      = 3'b000;
      #1;
      rst_n = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         checks++;
         if ({floor, is_mooving, door_open, led_clr} !== 7'b00_0_0_000) begin
            failures++;
            $display("FAIL rstmid_idle_c%0d got=%b exp=%b", c, {floor, is_mooving, door_open, led_clr}, 7'b00_0_0_000);
         end
      end
   endtask

   task automatic test_door_hold();
      call = 3'b001;
      tick();
      checks++;
      if ({floor, door_open, led_clr} !== 6'b00_1_001) begin
         failures++;
         $display("FAIL hold_open got=%b exp=%b", {floor, door_open, led_clr}, 6'b00_1_001);
      end
      call      = 3'b000;
      door_hold = 1'b1;
      for (int c = 2; c <= 18; c++) begin
         tick();
         if (c == 11) door_hold = 1'b0;
         checks++;
         if (door_open !== (c < HOLD_CLOSE)) begin
            failures++;
            $display("FAIL hold_door_c%0d got=%b exp=%b", c, door_open, (c < HOLD_CLOSE));
         end
      end
   endtask

   initial begin
      test_reset();
      test_trip_up();
      test_down_to_2();
      test_call_at_floor();
      test_invalid_idle();
      test_ignore_midtrip();
      test_reset_mid_move();
      test_door_hold();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
